// File: rtl/card_cycle_ctrl.sv
// card_cycle_ctrl: schedules one punched-card feed cycle for the ES24 counter.
// A card is requested from the card source. Two brush passes of 16 timing
// points each then follow, brush 1 first and brush 2 second. Each timing point
// lasts STEP_DIV clocks, and its strobe is active in the second half of the
// point.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       run request (level); cards are fed continuously while high
//   card_valid  card source has a card ready (only looked at in FEED)
//   card_ack    1-cycle pulse, first cycle of brush 1 (card accepted)
//   brush       0 = brush 1 pass, 1 = brush 2 pass
//   point       one-hot timing-point strobe, indexed by row number
//   row         row under the brush (0..9, 11, 12), held for the whole step
//   row_valid   row holds a data row
//   card_done   1-cycle pulse after both passes complete
//   busy        high in every state except IDLE
// Every output is decoded from registered state only.
module card_cycle_ctrl #(
  parameter int STEP_DIV = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        card_valid,
  output logic        card_ack,
  output logic        brush,
  output logic [15:0] point,
  output logic [3:0]  row,
  output logic        row_valid,
  output logic        card_done,
  output logic        busy
);

  localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(STEP_DIV / 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FEED   = 3'd1,
    S_BRUSH1 = 3'd2,
    S_BRUSH2 = 3'd3,
    S_END    = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      div_q   <= div_d;
    end
  end

  // Next state. Once a card is accepted, both passes always run to the end.
  // Dropping start only takes effect in END or FEED.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    div_d   = div_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_FEED;
      S_FEED: begin
        if (card_valid) begin
          state_d = S_BRUSH1;
          step_d  = '0;
          div_d   = '0;
        end else if (!start) begin
          state_d = S_IDLE;
        end
      end
      S_BRUSH1, S_BRUSH2: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (step_q == 4'd15) begin
            step_d  = '0;
            state_d = (state_q == S_BRUSH1) ? S_BRUSH2 : S_END;
          end else begin
            step_d = step_q + 4'd1;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_END:   state_d = start ? S_FEED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic       running;
  logic       strobe;
  logic [3:0] pidx;

  assign running = (state_q == S_BRUSH1) || (state_q == S_BRUSH2);

  // Steps 1..10 sense rows 9..0 (bottom of the card first). Steps 11 and 12
  // sense rows 11 and 12. Steps 13..15 only strobe their own point bit.
  // Because of this mapping, point[10] is never selected.
  assign pidx   = (step_q <= 4'd10) ? (4'd10 - step_q) : step_q;
  assign strobe = running && (step_q != 4'd0) && (div_q >= DIV_HALF);

  always_comb begin
    row       = '0;
    row_valid = 1'b0;
    if (running && step_q >= 4'd1 && step_q <= 4'd12) begin
      row       = pidx;
      row_valid = 1'b1;
    end
  end

  always_comb begin
    point = '0;
    if (strobe) point[pidx] = 1'b1;
  end

  // BRUSH1 with step 0 and div 0 can only occur in the first cycle after FEED.
  assign card_ack  = (state_q == S_BRUSH1) && (step_q == 4'd0) && (div_q == '0);
  assign brush     = (state_q == S_BRUSH2);
  assign card_done = (state_q == S_END);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_card_cycle_ctrl.sv
module tb_card_cycle_ctrl;
  localparam int D    = 4;
  localparam int CARD = 32 * D;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        card_valid = 1'b0;
  logic        card_ack, brush, row_valid, card_done, busy;
  logic [15:0] point;
  logic [3:0]  row;

  int checks = 0;
  int failures = 0;

  card_cycle_ctrl #(.STEP_DIV(D)) dut (
    .clk(clk), .reset(reset), .start(start), .card_valid(card_valid),
    .card_ack(card_ack), .brush(brush), .point(point), .row(row),
    .row_valid(row_valid), .card_done(card_done), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [24:0] dut_vec;
  assign dut_vec = {card_ack, brush, point, row, row_valid, card_done, busy};

  // Reference model. mode: 0 idle, 1 waiting for a card, 2 card in the
  // brushes, 3 done. t counts clocks since the card was accepted. All timing
  // outputs are derived from t with plain arithmetic.
  int mode_m = 0;
  int t_m = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_m <= 0;
      t_m    <= 0;
    end else begin
      case (mode_m)
        0: if (start) mode_m <= 1;
        1: if (card_valid) begin mode_m <= 2; t_m <= 0; end
           else if (!start) mode_m <= 0;
        2: if (t_m == CARD - 1) mode_m <= 3; else t_m <= t_m + 1;
        default: mode_m <= start ? 1 : 0;
      endcase
    end
  end

  function automatic logic [24:0] exp_out();
    logic ack, br, rv, dn, bz;
    logic [15:0] pt;
    logic [3:0] rw;
    int p, st, dv;
    ack = 0; br = 0; rv = 0; pt = '0; rw = '0;
    bz = (mode_m != 0);
    dn = (mode_m == 3);
    if (mode_m == 2) begin
      ack = (t_m == 0);
      br  = (t_m >= 16 * D);
      p   = t_m % (16 * D);
      st  = p / D;
      dv  = p % D;
      if (st >= 1 && st <= 10) begin rw = 4'(10 - st); rv = 1; end
      else if (st == 11 || st == 12) begin rw = 4'(st); rv = 1; end
      if (st >= 1 && dv >= D / 2) pt[(st <= 10) ? 10 - st : st] = 1'b1;
    end
    return {ack, br, pt, rw, rv, dn, bz};
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; card_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== 25'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%h exp=%h", dut_vec, 25'd0);
      end
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_and_points();
    bit found = 0;
    int acks = 0;
    start = 1'b1; card_valid = 1'b1;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mode_m == 2 && t_m == 0) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL basic_start got=timeout exp=card_accepted");
    end
    for (int k = 0; k <= CARD; k++) begin
      if (k > 0) @(negedge clk);
      checks++;
      if (dut_vec !== exp_out()) begin
        failures++;
        $display("FAIL basic_model k=%0d got=%h exp=%h", k, dut_vec, exp_out());
      end
      if (card_ack) acks++;
      checks++;
      if (brush !== (k >= 64 && k < 128)) begin
        failures++;
        $display("FAIL basic_brush k=%0d got=%b", k, brush);
      end
      checks++;
      if (point[10] !== 1'b0 || !$onehot0(point)) begin
        failures++;
        $display("FAIL point_onehot k=%0d got=%h", k, point);
      end
      if (k >= 4 && k <= 7) begin
        checks++;
        if (row !== 4'd9 || row_valid !== 1'b1 || point !== ((k >= 6) ? 16'h0200 : 16'h0)) begin
          failures++;
          $display("FAIL step1_row9 k=%0d got row=%0d rv=%b pt=%h", k, row, row_valid, point);
        end
      end
      if (k == 42 || k == 46 || k == 50 || k == 40 || k == 44 || k == 48) begin
        checks++;
        if (point !== (k == 42 ? 16'h0001 : k == 46 ? 16'h0800 : k == 50 ? 16'h1000 : 16'h0)) begin
          failures++;
          $display("FAIL steps10_12_point k=%0d got=%h", k, point);
        end
      end
      if (k == CARD) begin
        checks++;
        if (card_done !== 1'b1) begin
          failures++;
          $display("FAIL basic_done got=%b exp=1", card_done);
        end
      end
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL basic_ack_count got=%0d exp=1", acks);
    end
    card_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || point !== 16'h0 || card_ack !== 1'b0 || card_done !== 1'b0) begin
      failures++;
      $display("FAIL basic_back_to_feed got=%h", dut_vec);
    end
  endtask

  task automatic test_feed_stall();
    int bad = 0;
    start = 1'b1; card_valid = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b1 || point !== 16'h0 || card_ack !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL feed_stall bad_cycles got=%0d exp=0", bad);
    end
    card_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (card_ack !== 1'b1) begin
      failures++;
      $display("FAIL stall_release_ack got=%b exp=1", card_ack);
    end
  endtask

  task automatic test_stop_mid();
    int acks = 0;
    bit done_seen = 0;
    repeat (20) @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 200 && !done_seen; i++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_out()) begin
        failures++;
        $display("FAIL stop_model got=%h exp=%h", dut_vec, exp_out());
      end
      if (card_ack) acks++;
      if (mode_m == 3) begin
        done_seen = 1;
        checks++;
        if (card_done !== 1'b1) begin
          failures++;
          $display("FAIL stop_done got=%b exp=1", card_done);
        end
      end
    end
    checks++;
    if (!done_seen) begin
      failures++;
      $display("FAIL stop_done_timeout got=none exp=card_done");
    end
    repeat (50) begin
      @(negedge clk);
      if (card_ack || busy) acks++;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL stop_idle got=%0d active_cycles exp=0", acks);
    end
  endtask

  task automatic test_back_to_back();
    int ack_at[$];
    start = 1'b1; card_valid = 1'b1;
    for (int c = 0; c < 3 * (CARD + 2) + 10; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_out()) begin
        failures++;
        $display("FAIL b2b_model c=%0d got=%h exp=%h", c, dut_vec, exp_out());
      end
      if (card_ack) ack_at.push_back(c);
    end
    checks++;
    if (ack_at.size() < 3) begin
      failures++;
      $display("FAIL b2b_ack_count got=%0d exp=3", ack_at.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (ack_at[i] - ack_at[i-1] != CARD + 2) begin
          failures++;
          $display("FAIL b2b_spacing got=%0d exp=%0d", ack_at[i] - ack_at[i-1], CARD + 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    start = 1'b1; card_valid = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (mode_m == 2 && t_m == 16 * D + 7 * D + 1) found = 1;
    end
    checks++;
    if (!found || brush !== 1'b1 || row !== 4'd3) begin
      failures++;
      $display("FAIL resetmid_reach got found=%b brush=%b row=%0d exp=1,1,3", found, brush, row);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dut_vec !== 25'd0) begin
      failures++;
      $display("FAIL resetmid_async got=%h exp=0", dut_vec);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== 25'd0) begin
        failures++;
        $display("FAIL resetmid_hold got=%h exp=0", dut_vec);
      end
    end
    card_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (dut_vec !== 25'd1 || dut_vec !== exp_out()) begin
      failures++;
      $display("FAIL resetmid_feed got=%h exp=%h", dut_vec, 25'd1);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      checks++;
      if (dut_vec !== exp_out()) begin
        failures++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_vec, exp_out());
      end
      start      = ($urandom_range(0, 9) < 8);
      card_valid = ($urandom_range(0, 1) == 1);
    end
  endtask

  initial begin
    test_reset();
    test_basic_and_points();
    test_feed_stall();
    test_stop_mid();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/card_cycle_ctrl.md
Name: card_cycle_ctrl

Overview:
- Sequences one punched-card feed cycle for the ES24 counter.
- Requests a card from the card source, then runs two brush passes: brush 1 first, then brush 2. Each pass has 16 timing points.
- Drives the one-hot timing-point pulses, the sensed row index and the brush select. These gate card data into the ES24 inputs (aufnahme, umkehr, minus, löschen, zählerananalyse, digit input).
- Replaces the free-running brush timing with a start/stop-controlled scheduler.

Parameters:
- STEP_DIV, 64: clk cycles per timing point. Must be even and >= 2.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  run request (level). While high, cards are fed continuously.
- card_valid  in  1  card source has a card ready.
- card_ack  out  1  one-cycle pulse: card accepted into the feed.
- brush  out  1  0 = brush 1 pass, 1 = brush 2 pass.
- point  out  16  one-hot timing-point pulse, indexed by row number.
- row  out  4  row currently under the brush (0..9, 11, 12).
- row_valid  out  1  row holds a data row.
- card_done  out  1  one-cycle pulse: both passes of the card are complete.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are decoded from registered state only. There is no combinational input-to-output path.
- Reset (asynchronous, active-low) forces:
  - state = IDLE, step = 0, div = 0.
  - All outputs = 0.
  - This applies mid-pass too: no card_done is issued for the aborted card.
- States: IDLE, FEED, BRUSH1, BRUSH2, END.
- IDLE:
  - start = 1 → FEED on the next edge.
- FEED (busy = 1):
  - Waits indefinitely for card_valid.
  - card_valid = 1 at an edge → BRUSH1 with step = 0 and div = 0.
  - card_ack is 1 during the first BRUSH1 cycle only.
  - start = 0 while in FEED with card_valid = 0 → IDLE.
- BRUSH1 / BRUSH2:
  - div counts 0..STEP_DIV-1. On wrap, step increments 0..15.
  - Step 15 with div = STEP_DIV-1: BRUSH1 → BRUSH2 (step = 0, div = 0), and BRUSH2 → END.
  - brush = 1 exactly while in BRUSH2.
  - Step-to-row map:
    - step 0: no row, no pulse.
    - steps 1..10: rows 9..0.
    - step 11: row 11. Step 12: row 12.
    - steps 13, 14, 15: point bits 13, 14, 15; row_valid = 0.
  - point[r] = 1 only while the step maps to r and div >= STEP_DIV/2 (strobe window = second half of the step).
  - point[10] is always 0. At most one point bit is high at any time.
  - row and row_valid hold for the whole step (steps 1..12). Otherwise row = 0 and row_valid = 0.
- END (one cycle):
  - card_done = 1.
  - Next state is FEED if start = 1, else IDLE.
- start deasserted during BRUSH1/BRUSH2: the current card completes both passes and card_done is issued, then → IDLE.
- card_valid is ignored outside FEED.
- Cycle count from card_ack to card_done = 32*STEP_DIV. With STEP_DIV = 64 this is 2048 cycles.

Test Plan:
- Basic cycle (STEP_DIV = 4; reset low for 3 cycles then high; start = 1; card_valid = 1):
  - card_ack pulses once.
  - brush = 0 for cycles 0..63 after the ack, brush = 1 for cycles 64..127.
  - card_done = 1 at cycle 128, then FEED.
- Point timing (STEP_DIV = 4):
  - Step 1 spans cycles 4..7. row = 9 and row_valid = 1 across cycles 4..7; point[9] = 1 in cycles 6..7 only.
  - Step 10: point[0]. Step 11: point[11]. Step 12: point[12].
  - point[10] is never 1. $onehot0(point) holds in every cycle.
- Feed stall: start = 1, card_valid = 0 for 50 cycles → busy = 1, point = 0, no card_ack. card_valid = 1 → card_ack on the next cycle.
- Stop mid-card: start drops at cycle 20 of BRUSH1 → both passes complete, card_done pulses, state → IDLE, busy = 0, no second card_ack.
- Back-to-back cards: start held, card_valid held → card_ack pulses spaced 32*STEP_DIV + 2 cycles apart.
- Reset mid-pass: reset pulled low during BRUSH2 step 7 → all outputs 0 immediately (asynchronous); no card_done. After release with start = 1 → FEED.
